m14k_tagram_seq: RTL and testbench
==================================

# m14k_tagram_seq

Sequencer and arbiter in front of the cache tag RAM wrapper. After reset, and on software request, it performs hardware cache initialization: it walks every line index and writes zero tags to all ways. In normal operation it shares the single tag RAM port between pipeline lookups and fills (priority requester) and CACHE-op invalidates (secondary requester). An anti-starvation counter guarantees that invalidates make forward progress.

## Interface
- ASSOC, 2, number of ways; width of the RAM word write mask
- LINE_IDX_SIZE, 7, tag RAM index width; the walk covers 2^LINE_IDX_SIZE lines
- WORD_WIDTH, 24, tag word width; ram_wr_data width
- STARVE_LIMIT, 4, consecutive denied cycles of inv_req before invalidate wins; range 1..15
- clk  in  1  clock; all state changes on the rising edge
- greset_n  in  1  asynchronous, active-low reset
- hci_en  in  1  strap; sampled in WAIT to decide whether the hardware init walk runs after reset
- init_start  in  1  single-cycle pulse requesting a re-init walk
- pipe_req  in  1  pipeline access request
- pipe_wr  in  1  pipeline request is a write (0 = read)
- pipe_idx  in  LINE_IDX_SIZE  pipeline line index
- pipe_mask  in  ASSOC  pipeline way write mask
- pipe_wdata  in  WORD_WIDTH  pipeline write tag
- pipe_gnt  out  1  pipeline access issued to RAM this cycle
- inv_req  in  1  invalidate request; held high until acked
- inv_idx  in  LINE_IDX_SIZE  invalidate line index
- inv_way  in  ASSOC  ways to invalidate
- inv_ack  out  1  invalidate issued this cycle
- ram_line_idx  out  LINE_IDX_SIZE  to tag RAM line_idx
- ram_wr_mask  out  ASSOC  to tag RAM wr_mask
- ram_rd_str  out  1  to tag RAM rd_str
- ram_wr_str  out  1  to tag RAM wr_str
- ram_wr_data  out  WORD_WIDTH  to tag RAM wr_data
- ram_early_ce  out  1  to tag RAM early_ce
- hci  out  1  high while an init walk is in progress
- init_done  out  1  high in RUN after at least one completed walk since reset

## Operation
- FSM states: WAIT, WALK, RUN. greset_n low forces WAIT asynchronously. It also clears walk_cnt, starve_cnt and init_done.
- WAIT: lasts exactly one cycle after reset deassertion. Next state is WALK if hci_en = 1, otherwise RUN. In the hci_en = 0 case init_done stays 0.
- WALK: each cycle drives ram_wr_str = 1, ram_wr_mask = all ones, ram_wr_data = 0 and ram_line_idx = walk_cnt, then increments walk_cnt.
  - Exit: on the cycle walk_cnt = 2^LINE_IDX_SIZE - 1, issue that write, go to RUN, set init_done = 1, and let walk_cnt wrap to 0.
  - In WALK, pipe_gnt = 0 and inv_ack = 0. init_start is ignored, and the current walk completes.
- RUN, priority order:
  1. init_start = 1: go to WALK. No grant and no RAM strobe this cycle. walk_cnt = 0.
  2. inv_req = 1 and starve_cnt = STARVE_LIMIT: issue the invalidate.
  3. pipe_req = 1: issue the pipeline access.
  4. inv_req = 1: issue the invalidate.
- Pipeline issue:
  - pipe_gnt = 1; ram_line_idx = pipe_idx.
  - Read (pipe_wr = 0): ram_rd_str = 1.
  - Write (pipe_wr = 1): ram_wr_str = 1, ram_wr_mask = pipe_mask, ram_wr_data = pipe_wdata.
- Invalidate issue: inv_ack = 1, ram_wr_str = 1, ram_line_idx = inv_idx, ram_wr_mask = inv_way, ram_wr_data = 0.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, each RUN cycle in which inv_req = 1 and inv_ack = 0.
  - Clears to 0 when inv_ack = 1, when inv_req = 0, or on entry to WALK.
- ram_rd_str and ram_wr_str are never both 1.
- With no strobe active, ram_wr_mask = 0, ram_wr_data = 0 and ram_line_idx = 0.
- ram_early_ce = 1 in WALK, and in RUN whenever pipe_req or inv_req is high.
- hci = 1 exactly when the state is WALK.

## Timing
- Grants and RAM port outputs are combinational from the state and the current requests, in the same cycle. The RAM captures them on the next rising edge. Read data appears per the RAM wrapper latency and is not routed through this block.
- Walk duration is 2^LINE_IDX_SIZE cycles, one write per cycle with no bubbles.
- First RUN cycle: WAIT + 2^LINE_IDX_SIZE cycles after reset release when hci_en = 1; WAIT + 1 otherwise.
- Reset values: every output 0; state WAIT; all counters 0.
- Reset mid-walk aborts the walk immediately. It restarts from index 0 if hci_en = 1 after release.
- init_start and pipe_req in the same cycle: init wins, pipe_gnt = 0, and the requester retries.
- Worst-case invalidate wait under continuous pipe_req is STARVE_LIMIT + 1 cycles.

## Test plan
- Reset with hci_en = 1, LINE_IDX_SIZE = 7 -> hci high for 128 cycles; writes to indices 0..127, each with mask 2'b11 and data 0; init_done = 1 on the following cycle; pipe_gnt = 0 throughout the walk.
- Reset with hci_en = 0 -> RUN after 1 cycle with no RAM strobes; init_done stays 0; pipe_req read of idx 5 gives pipe_gnt = 1, ram_rd_str = 1, ram_line_idx = 5 in the same cycle.
- inv_req for idx 9, way 2'b10, with pipe_req held high and STARVE_LIMIT = 4 -> pipe_gnt for 4 cycles, then inv_ack on the 5th cycle with ram_wr_mask = 2'b10 and ram_wr_data = 0; starve_cnt returns to 0.
- init_start in RUN together with pipe_req -> no grant that cycle; hci rises on the next cycle; a 128-cycle walk; init_start pulses during the walk do not restart it.
- greset_n asserted at walk index 60 -> all outputs 0 immediately; after release with hci_en = 1 the walk restarts at index 0.
- pipe write idx 3, mask 2'b01, data 24'hABCDEF -> ram_wr_str = 1 and ram_rd_str = 0 with the exact index, mask and data; the same-cycle inv_req is not acked.

Source files
------------

// File: rtl/m14k_tagram_seq.sv
// Tag RAM port sequencer: runs the hardware cache-init walk, then arbitrates the
// single tag RAM port between pipeline accesses and starvation-protected invalidates.
module m14k_tagram_seq #(
    parameter int ASSOC         = 2,
    parameter int LINE_IDX_SIZE = 7,
    parameter int WORD_WIDTH    = 24,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                     clk,
    input  logic                     greset_n,
    input  logic                     hci_en,
    input  logic                     init_start,
    input  logic                     pipe_req,
    input  logic                     pipe_wr,
    input  logic [LINE_IDX_SIZE-1:0] pipe_idx,
    input  logic [ASSOC-1:0]         pipe_mask,
    input  logic [WORD_WIDTH-1:0]    pipe_wdata,
    output logic                     pipe_gnt,
    input  logic                     inv_req,
    input  logic [LINE_IDX_SIZE-1:0] inv_idx,
    input  logic [ASSOC-1:0]         inv_way,
    output logic                     inv_ack,
    output logic [LINE_IDX_SIZE-1:0] ram_line_idx,
    output logic [ASSOC-1:0]         ram_wr_mask,
    output logic                     ram_rd_str,
    output logic                     ram_wr_str,
    output logic [WORD_WIDTH-1:0]    ram_wr_data,
    output logic                     ram_early_ce,
    output logic                     hci,
    output logic                     init_done
);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_WALK = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [LINE_IDX_SIZE-1:0] LAST_IDX   = '1;
    localparam logic [3:0]               STARVE_MAX = 4'(STARVE_LIMIT);

    state_t                     r_state;
    state_t                     w_next_state;
    logic [LINE_IDX_SIZE-1:0]   r_walk_cnt;
    logic [3:0]                 r_starve_cnt;
    logic                       r_walked;
    logic                       w_inv_win;

    // NOTE: state and counters use non-blocking assignments so every flop samples
    // the pre-edge values, independent of the order the always blocks run in.
    always_ff @(posedge clk or negedge greset_n) begin
        if (!greset_n) r_state <= ST_WAIT;
        else           r_state <= w_next_state;
    end

    // Invalidate wins once it has been denied STARVE_LIMIT times in a row.
    assign w_inv_win = inv_req && ((r_starve_cnt == STARVE_MAX) || !pipe_req);

    // NOTE: every output and the next state get a default before the case so that
    // no path leaves them unassigned, which would otherwise infer latches.
    always_comb begin
        w_next_state = r_state;
        pipe_gnt     = 1'b0;
        inv_ack      = 1'b0;
        ram_line_idx = '0;
        ram_wr_mask  = '0;
        ram_rd_str   = 1'b0;
        ram_wr_str   = 1'b0;
        ram_wr_data  = '0;
        ram_early_ce = 1'b0;
        hci          = 1'b0;
        unique case (r_state)
            ST_WAIT: begin
                w_next_state = hci_en ? ST_WALK : ST_RUN;
            end
            ST_WALK: begin
                hci          = 1'b1;
                ram_early_ce = 1'b1;
                ram_wr_str   = 1'b1;
                ram_wr_mask  = '1;
                ram_line_idx = r_walk_cnt;
                if (r_walk_cnt == LAST_IDX) w_next_state = ST_RUN;
            end
            ST_RUN: begin
                ram_early_ce = pipe_req || inv_req;
                if (init_start) begin
                    w_next_state = ST_WALK;
                end else if (w_inv_win) begin
                    inv_ack      = 1'b1;
                    ram_wr_str   = 1'b1;
                    ram_line_idx = inv_idx;
                    ram_wr_mask  = inv_way;
                end else if (pipe_req) begin
                    pipe_gnt     = 1'b1;
                    ram_line_idx = pipe_idx;
                    if (pipe_wr) begin
                        ram_wr_str  = 1'b1;
                        ram_wr_mask = pipe_mask;
                        ram_wr_data = pipe_wdata;
                    end else begin
                        ram_rd_str  = 1'b1;
                    end
                end
            end
            default: w_next_state = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge greset_n) begin
        if (!greset_n) begin
            r_walk_cnt   <= '0;
            r_starve_cnt <= '0;
            r_walked     <= 1'b0;
        end else begin
            if (r_state == ST_WALK) begin
                // Wraps to 0 on the last index, ready for the next walk.
                r_walk_cnt <= r_walk_cnt + 1'b1;
                if (r_walk_cnt == LAST_IDX) r_walked <= 1'b1;
            end else if (r_state == ST_RUN && init_start) begin
                r_walk_cnt <= '0;
            end

            if (r_state == ST_RUN) begin
                if (init_start || !inv_req || inv_ack) r_starve_cnt <= '0;
                else if (r_starve_cnt != STARVE_MAX)   r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end
    end

    assign init_done = r_walked && (r_state == ST_RUN);

endmodule

// File: tb/tb_m14k_tagram_seq.sv
// Randomized self-checking bench for m14k_tagram_seq against a cycle-level
// behavioural model of the init walk and the starvation-protected arbiter.
module tb_m14k_tagram_seq;

    localparam int ASSOC = 2;
    localparam int LIS   = 7;
    localparam int WW    = 24;
    localparam int LIMIT = 4;
    localparam int LINES = 1 << LIS;

    logic            clk = 1'b0;
    logic            greset_n;
    logic            hci_en;
    logic            init_start;
    logic            pipe_req;
    logic            pipe_wr;
    logic [LIS-1:0]  pipe_idx;
    logic [ASSOC-1:0] pipe_mask;
    logic [WW-1:0]   pipe_wdata;
    logic            pipe_gnt;
    logic            inv_req;
    logic [LIS-1:0]  inv_idx;
    logic [ASSOC-1:0] inv_way;
    logic            inv_ack;
    logic [LIS-1:0]  ram_line_idx;
    logic [ASSOC-1:0] ram_wr_mask;
    logic            ram_rd_str;
    logic            ram_wr_str;
    logic [WW-1:0]   ram_wr_data;
    logic            ram_early_ce;
    logic            hci;
    logic            init_done;

    m14k_tagram_seq #(
        .ASSOC(ASSOC), .LINE_IDX_SIZE(LIS), .WORD_WIDTH(WW), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .greset_n(greset_n), .hci_en(hci_en), .init_start(init_start),
        .pipe_req(pipe_req), .pipe_wr(pipe_wr), .pipe_idx(pipe_idx),
        .pipe_mask(pipe_mask), .pipe_wdata(pipe_wdata), .pipe_gnt(pipe_gnt),
        .inv_req(inv_req), .inv_idx(inv_idx), .inv_way(inv_way), .inv_ack(inv_ack),
        .ram_line_idx(ram_line_idx), .ram_wr_mask(ram_wr_mask),
        .ram_rd_str(ram_rd_str), .ram_wr_str(ram_wr_str), .ram_wr_data(ram_wr_data),
        .ram_early_ce(ram_early_ce), .hci(hci), .init_done(init_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: phase 0 = waiting one cycle after reset, 1 = walking, 2 = running.
    int m_phase;
    int m_walk;
    int m_denied;
    bit m_done;
    bit m_ack_pred;

    logic obs_gnt, obs_ack, obs_hci, obs_rd, obs_wr;
    logic [LIS-1:0]  obs_idx;
    logic [ASSOC-1:0] obs_mask;
    logic [WW-1:0]   obs_data;

    bit            pend;
    logic [LIS-1:0]  pend_idx;
    logic [ASSOC-1:0] pend_way;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_walk   = 0;
        m_denied = 0;
        m_done   = 0;
    endtask

    // Called just after a falling edge with inputs already driven: compares the
    // combinational outputs, advances the model, and waits for the next falling edge.
    task automatic step();
        logic e_gnt, e_ack, e_rd, e_wr, e_ce, e_hci, e_done;
        logic [LIS-1:0]  e_idx;
        logic [ASSOC-1:0] e_mask;
        logic [WW-1:0]   e_data;
        logic [63:0]     got, exp;
        #1;
        if (!greset_n) model_reset();
        {e_gnt, e_ack, e_rd, e_wr, e_ce, e_hci} = '0;
        e_idx = '0; e_mask = '0; e_data = '0;
        m_ack_pred = 0;
        if (m_phase == 1) begin
            e_hci = 1; e_ce = 1; e_wr = 1; e_mask = '1; e_idx = LIS'(m_walk);
        end else if (m_phase == 2) begin
            e_ce = pipe_req | inv_req;
            if (!init_start) begin
                if (inv_req && (m_denied >= LIMIT || !pipe_req)) begin
                    m_ack_pred = 1;
                    e_ack = 1; e_wr = 1; e_idx = inv_idx; e_mask = inv_way;
                end else if (pipe_req) begin
                    e_gnt = 1; e_idx = pipe_idx;
                    if (pipe_wr) begin
                        e_wr = 1; e_mask = pipe_mask; e_data = pipe_wdata;
                    end else begin
                        e_rd = 1;
                    end
                end
            end
        end
        e_done = m_done && (m_phase == 2);
        exp = 64'({e_gnt, e_ack, e_idx, e_mask, e_rd, e_wr, e_data, e_ce, e_hci, e_done});
        got = 64'({pipe_gnt, inv_ack, ram_line_idx, ram_wr_mask, ram_rd_str, ram_wr_str,
                   ram_wr_data, ram_early_ce, hci, init_done});
        check("cycle_outputs", got, exp);
        {obs_gnt, obs_ack, obs_hci, obs_rd, obs_wr} = {pipe_gnt, inv_ack, hci, ram_rd_str, ram_wr_str};
        obs_idx = ram_line_idx; obs_mask = ram_wr_mask; obs_data = ram_wr_data;

        if (greset_n) begin
            case (m_phase)
                0: m_phase = hci_en ? 1 : 2;
                1: begin
                    if (m_walk == LINES - 1) begin
                        m_phase = 2; m_done = 1; m_walk = 0;
                    end else begin
                        m_walk++;
                    end
                end
                default: begin
                    if (init_start) begin
                        m_phase = 1; m_walk = 0; m_denied = 0;
                    end else if (inv_req && !m_ack_pred) begin
                        m_denied = (m_denied + 1 > LIMIT) ? LIMIT : m_denied + 1;
                    end else begin
                        m_denied = 0;
                    end
                end
            endcase
        end
        @(negedge clk);
    endtask

    task automatic rand_inputs(input int init_odds);
        init_start = (init_odds != 0) && ($urandom_range(init_odds - 1) == 0);
        pipe_req   = 1'($urandom);
        pipe_wr    = 1'($urandom);
        pipe_idx   = LIS'($urandom);
        pipe_mask  = ASSOC'($urandom);
        pipe_wdata = WW'($urandom);
        if (!pend && $urandom_range(2) == 0) begin
            pend     = 1;
            pend_idx = LIS'($urandom);
            pend_way = ASSOC'($urandom);
        end
        inv_req = pend;
        inv_idx = pend_idx;
        inv_way = pend_way;
    endtask

    task automatic rand_step(input int init_odds);
        rand_inputs(init_odds);
        step();
        if (m_ack_pred) pend = 0;
    endtask

    task automatic idle_inputs();
        {init_start, pipe_req, pipe_wr, inv_req} = '0;
        pipe_idx = '0; pipe_mask = '0; pipe_wdata = '0; inv_idx = '0; inv_way = '0;
        pend = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int hci_cnt;
        int waited;
        model_reset();
        idle_inputs();
        pend_idx = '0; pend_way = '0;
        greset_n = 0;
        hci_en   = 1;
        @(negedge clk);
        step();
        step();

        // Power-up walk with random traffic and stray init_start pulses.
        greset_n = 1;
        hci_cnt  = 0;
        for (int i = 0; i < 200 && !(m_phase == 2 && i > 0); i++) begin
            rand_step(0);
            if (m_phase == 1 && m_walk == 50) init_start = 1;
            hci_cnt += int'(obs_hci);
        end
        check("walk_len", 64'(hci_cnt), 64'(LINES));
        check("walk_done_phase", 64'(m_phase), 64'd2);

        for (int i = 0; i < 600; i++) rand_step(64);

        // Re-init together with pipe_req, then reset at walk index 60.
        while (m_phase != 2) rand_step(0);
        idle_inputs();
        init_start = 1; pipe_req = 1; pipe_idx = 7'd4;
        step();
        check("init_no_gnt", 64'(obs_gnt), 64'd0);
        init_start = 0;
        for (int i = 0; i < 200 && !(m_phase == 1 && m_walk == 60); i++) rand_step(8);
        check("walk_at_60", 64'(obs_idx), 64'd59);
        idle_inputs();
        greset_n = 0;
        step();
        check("rst_mid_walk_hci", 64'(obs_hci), 64'd0);
        check("rst_mid_walk_wr", 64'(obs_wr), 64'd0);
        hci_en   = 1;
        greset_n = 1;
        step();
        step();
        check("restart_idx0", 64'({obs_hci, obs_wr, obs_idx}), 64'({1'b1, 1'b1, 7'd0}));
        for (int i = 0; i < 140 && m_phase != 2; i++) rand_step(0);
        for (int i = 0; i < 200; i++) rand_step(32);

        // Reset without the init walk.
        idle_inputs();
        greset_n = 0;
        step();
        hci_en   = 0;
        greset_n = 1;
        step();
        check("no_walk_done", 64'(init_done), 64'd0);
        pipe_req = 1; pipe_wr = 0; pipe_idx = 7'd5;
        step();
        check("rd5", 64'({obs_gnt, obs_rd, obs_wr, obs_idx}), 64'({1'b1, 1'b1, 1'b0, 7'd5}));

        // Starvation: pipe_req held, invalidate idx 9 way 2'b10.
        step();
        inv_req = 1; inv_idx = 7'd9; inv_way = 2'b10;
        waited = 0;
        for (int i = 0; i < 20; i++) begin
            waited++;
            step();
            if (obs_ack) break;
        end
        check("starve_wait", 64'(waited), 64'(LIMIT + 1));
        check("starve_inv", 64'({obs_mask, obs_data, obs_idx}), 64'({2'b10, 24'd0, 7'd9}));
        inv_req = 0;
        step();

        // Pipe write with a competing invalidate that must lose.
        pipe_req = 1; pipe_wr = 1; pipe_idx = 7'd3; pipe_mask = 2'b01; pipe_wdata = 24'hABCDEF;
        inv_req = 1; inv_idx = 7'd20; inv_way = 2'b11;
        step();
        check("wr3", 64'({obs_gnt, obs_ack, obs_rd, obs_wr, obs_idx, obs_mask, obs_data}),
              64'({1'b1, 1'b0, 1'b0, 1'b1, 7'd3, 2'b01, 24'hABCDEF}));
        idle_inputs();
        step();

        for (int i = 0; i < 400; i++) rand_step(100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
